// File: rtl/spike_weight_network.sv
// rtl/spike_weight_network.sv - tick-paced weighted rate-divider synapses feeding an integrate-and-fire neuron
module spike_weight_network #(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 7,
    parameter bit [HEIGHT-1:0][WIDTH:0] WEIGHTS =
        {9'd60, 9'd60, 9'd60, 9'd260, 9'd260, 9'd260, 9'd260},
    parameter int THRESHOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HEIGHT-1:0] pixels,
    output logic              neuron_out
);

    localparam int CNT_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int ACC_W = $clog2(THRESHOLD + HEIGHT) + 1;
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] ONE      = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] THRESH_S = SUM_W'(THRESHOLD);

    logic [CNT_W-1:0]              tick_cnt_q, tick_cnt_d;
    logic                          tick;
    logic [HEIGHT-1:0][WIDTH-1:0]  syn_cnt_q, syn_cnt_d;
    logic [HEIGHT-1:0]             fire;
    logic [HEIGHT-1:0]             pos_q, pos_d;
    logic [ACC_W-1:0]              acc_q, acc_d;
    logic                          neuron_out_q, neuron_out_d;
    logic signed [SUM_W-1:0]       net, acc_sum;

    always_comb begin
        tick       = (tick_cnt_q == CNT_W'(HEIGHT - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    end

    // Each synapse divides its pixel's tick rate by its weight magnitude; a zero
    // magnitude disables the channel instead of underflowing the match value.
    always_comb begin
        syn_cnt_d = syn_cnt_q;
        fire      = '0;
        pos_d     = pos_q;
        net       = '0;
        for (int i = 0; i < HEIGHT; i++) begin
            if (tick && pixels[i] && (WEIGHTS[i][WIDTH-1:0] != '0)) begin
                if (syn_cnt_q[i] == WEIGHTS[i][WIDTH-1:0] - WIDTH'(1)) begin
                    fire[i]      = 1'b1;
                    syn_cnt_d[i] = '0;
                end else begin
                    syn_cnt_d[i] = syn_cnt_q[i] + WIDTH'(1);
                end
            end
            if (tick) begin
                pos_d[i] = fire[i] & ~WEIGHTS[i][WIDTH];
            end
            if (pos_q[i]) begin
                net = net + ONE;
            end
            if (fire[i] && WEIGHTS[i][WIDTH]) begin
                net = net - ONE;
            end
        end
    end

    always_comb begin
        acc_sum      = $signed({1'b0, acc_q}) + net;
        acc_d        = acc_q;
        neuron_out_d = 1'b0;
        if (tick) begin
            if (acc_sum[SUM_W-1]) begin
                acc_d = '0;
            end else if (acc_sum >= THRESH_S) begin
                acc_d        = '0;
                neuron_out_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q   <= '0;
            syn_cnt_q    <= '0;
            pos_q        <= '0;
            acc_q        <= '0;
            neuron_out_q <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            syn_cnt_q    <= syn_cnt_d;
            pos_q        <= pos_d;
            acc_q        <= acc_d;
            neuron_out_q <= neuron_out_d;
        end
    end

    assign neuron_out = neuron_out_q;

endmodule

// File: tb/tb_spike_weight_network.sv
// tb/tb_spike_weight_network.sv - directed and randomized checks of spike_weight_network against a tick-level model
module tb_spike_weight_network;

    localparam int H = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] px_a = '0, px_b = '0, px_c = '0;
    logic       out_a, out_b, out_c;

    int total = 0;
    int bad   = 0;

    int wmag [3][7];
    bit winh [3][7];
    int cnt  [3][7];
    bit pos  [3][7];
    int acc  [3];
    bit exp_out [3];
    bit nxt_out [3];
    int npulse [3];
    int first_cyc [3];
    int tq0 [$];
    int phase, tick_no, cyc;
    bit rnd_a = 1'b0, rnd_bc = 1'b0;

    spike_weight_network dut_a (
        .clk(clk), .rst(rst), .pixels(px_a), .neuron_out(out_a)
    );
    spike_weight_network #(
        .WEIGHTS({9'd60, 9'd60, 9'd60, 9'd260, 9'd260, 9'd260, 9'd1})
    ) dut_b (
        .clk(clk), .rst(rst), .pixels(px_b), .neuron_out(out_b)
    );
    spike_weight_network #(
        .WEIGHTS({9'd60, 9'd60, 9'd60, 9'd260, 9'd260, 9'd260, 9'd0})
    ) dut_c (
        .clk(clk), .rst(rst), .pixels(px_c), .neuron_out(out_c)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < H; i++) begin
                cnt[k][i] = 0;
                pos[k][i] = 1'b0;
            end
            acc[k]       = 0;
            exp_out[k]   = 1'b0;
            npulse[k]    = 0;
            first_cyc[k] = -1;
        end
        tq0.delete();
        phase   = 0;
        tick_no = 0;
        cyc     = 0;
    endtask

    // One tick of the neuron: pulses latched at the previous tick add, inhibitory
    // pulses of this tick subtract, the membrane floors at zero.
    task automatic model_tick();
        int         net;
        bit         np [7];
        logic [6:0] px;
        for (int k = 0; k < 3; k++) begin
            px  = (k == 0) ? px_a : (k == 1) ? px_b : px_c;
            net = 0;
            for (int i = 0; i < H; i++) begin
                net   = net + int'(pos[k][i]);
                np[i] = 1'b0;
            end
            for (int i = 0; i < H; i++) begin
                if (px[i] && wmag[k][i] > 0) begin
                    cnt[k][i]++;
                    if (cnt[k][i] == wmag[k][i]) begin
                        cnt[k][i] = 0;
                        if (winh[k][i]) net--;
                        else            np[i] = 1'b1;
                    end
                end
            end
            for (int i = 0; i < H; i++) pos[k][i] = np[i];
            acc[k] = acc[k] + net;
            if (acc[k] < 0) acc[k] = 0;
            nxt_out[k] = 1'b0;
            if (acc[k] >= 4) begin
                nxt_out[k] = 1'b1;
                acc[k]     = 0;
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int qat(input int i);
        return (i < tq0.size()) ? tq0[i] : -1;
    endfunction

    task automatic step();
        logic [2:0] o;
        if (rnd_a) px_a = 7'($urandom);
        if (rnd_bc) begin
            px_b = 7'($urandom);
            px_c = 7'($urandom);
        end
        #1;
        o = {out_c, out_b, out_a};
        for (int k = 0; k < 3; k++) begin
            total++;
            assert (o[k] === exp_out[k]) else begin
                bad++;
                $error("FAIL neuron_out[%0d] cyc=%0d tick=%0d observed=%b expected=%b",
                       k, cyc, tick_no, o[k], exp_out[k]);
            end
            if (o[k] === 1'b1) begin
                npulse[k]++;
                if (first_cyc[k] < 0) first_cyc[k] = cyc;
                if (k == 0) tq0.push_back(tick_no);
            end
            nxt_out[k] = 1'b0;
        end
        if (!rst && phase == H - 1) begin
            model_tick();
            tick_no++;
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) exp_out[k] = nxt_out[k];
        if (!rst) begin
            phase = (phase + 1) % H;
            cyc++;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_reset();
        repeat (n) step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_ticks(input int n);
        int target;
        int budget;
        target = tick_no + n;
        budget = n * H + H;
        while (tick_no < target && budget > 0) begin
            step();
            budget--;
        end
        check("tick_budget", tick_no, target);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < H; i++) begin
                wmag[k][i] = (i >= 4) ? 60 : 4;
                winh[k][i] = (i < 4);
            end
        end
        wmag[1][0] = 1; winh[1][0] = 1'b0;
        wmag[2][0] = 0; winh[2][0] = 1'b0;

        model_reset();
        @(negedge clk);
        do_reset(5);

        px_a = 7'b1000000;
        px_b = 7'b0000001;
        px_c = 7'b0000001;
        run_ticks(722);
        check("t2_npulse", tq0.size(), 3);
        check("t2_fire0", qat(0), 241);
        check("t2_fire1", qat(1), 481);
        check("t2_fire2", qat(2), 721);
        check("t5_w1_first_cyc", first_cyc[1], 35);
        check("t5_w1_npulse", npulse[1], 180);
        check("t5_w0_npulse", npulse[2], 0);

        do_reset(3);
        px_a   = 7'b1110000;
        rnd_bc = 1'b1;
        run_ticks(250);
        check("t3_npulse", tq0.size(), 2);
        check("t3_fire0", qat(0), 121);
        check("t3_fire1", qat(1), 241);

        do_reset(2);
        px_a = 7'b0101010;
        run_ticks(1024);
        check("t4a_npulse", npulse[0], 0);
        do_reset(2);
        px_a = 7'b1000001;
        run_ticks(1024);
        check("t4b_npulse", npulse[0], 0);

        do_reset(2);
        px_a = 7'b1000000;
        run_ticks(100);
        check("t6_pre_npulse", npulse[0], 0);
        do_reset(2);
        run_ticks(250);
        check("t6_npulse", tq0.size(), 1);
        check("t6_fire0", qat(0), 241);

        do_reset(2);
        rnd_a = 1'b1;
        run_ticks(400);
        do_reset(int'($urandom_range(1, 4)));
        run_ticks(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
